cdb_broadcast: RTL
==================

# cdb_broadcast

Completion-stage arbiter that collects finished results from all functional units and drives the N-wide common data bus (CDB) consumed by the reservation station, map table and ROB. Each FU owns a one-entry holding register. Up to N occupied registers are granted per cycle by rotating priority and broadcast as `CDB_PACKET`s. Held results carry a branch mask and are squashed or mask-cleared by the same `br_id`/`br_task` signals the reservation station uses.

## Interface
- `N`, default `` `N ``: CDB width, in broadcasts per cycle.
- `NUM_FU`, default `` `NUM_FU_ALU+`NUM_FU_MULT+`NUM_FU_LD+`NUM_FU_STORE+`NUM_FU_BR ``: number of result sources. Index order is ALU, MULT, LD, STORE, BR.
- `clock` in, 1: single clock; all state updates on posedge.
- `reset` in, 1: synchronous, active-high.
- `fu_valid` in, [NUM_FU]: FU i presents a result this cycle.
- `fu_reg_idx` in, [NUM_FU][`` `PHYS_REG_IDX_SZ ``]: destination physical register.
- `fu_value` in, [NUM_FU][`` `XLEN ``]: result data.
- `fu_b_mask` in, [NUM_FU] `BR_MASK`: branch mask of the producing instruction.
- `br_id` in, `BR_MASK`: one-hot branch being resolved.
- `br_task` in, `BR_TASK`: `NOTHING` / `SQUASH` / `CLEAR`.
- `fu_ready` out, [NUM_FU]: holding register i can accept this cycle.
- `cdb_out` out, [N] `CDB_PACKET`: broadcast slots with `valid`, `reg_idx`, `value`.

## Operation
- State per FU i: `hold_valid[i]`, `hold_reg_idx[i]`, `hold_value[i]`, `hold_b_mask[i]`. Also `ptr`, a `$clog2(NUM_FU)`-bit rotating priority pointer.
- **Squash filter (combinational):**
  - `live[i] = hold_valid[i] & ~(br_task==SQUASH & |(hold_b_mask[i] & br_id))`.
  - A squashed entry is not eligible this cycle and is invalidated at the edge.
- **Arbitration:**
  - Scan indices `ptr, ptr+1, … ptr+NUM_FU-1` (mod NUM_FU).
  - Grant the first min(N, popcount(live)) live entries.
  - The k-th grant drives `cdb_out[k]`. Ungranted slots output all-zero with valid=0.
- **Pointer update:**
  - If any grant: `ptr <= (last granted index + 1) mod NUM_FU`.
  - Otherwise `ptr` is unchanged.
- **Ready:** `fu_ready[i] = ~hold_valid[i] | granted[i] | squashed[i]`.
  - Combinational. FUs must not make `fu_valid` depend on `fu_ready`.
- **Accept:**
  - If `fu_valid[i] & fu_ready[i]`, the holding register i loads the incoming result at the edge.
  - Exception: under SQUASH, if `|(fu_b_mask[i] & br_id)`, the result is dropped (accepted, not stored).
- **CLEAR:**
  - Held entries: `hold_b_mask[i] &= ~br_id`.
  - Incoming results are stored with `fu_b_mask[i] & ~br_id`.
  - CLEAR does not affect eligibility.
- **Else:** a granted or squashed register becomes invalid. An ungranted live register holds its contents unchanged.
- **Protocol violation:** `fu_valid[i]` while `fu_ready[i]==0` is ignored. The held data is kept. The bench flags this as a protocol error.

## Timing
- **Reset values:**
  - All `hold_valid` = 0, `ptr` = 0.
  - `cdb_out` all zero (every slot valid=0).
  - `fu_ready` all 1.
- **Latency:**
  - A result accepted at edge k is eligible for broadcast in cycle k+1.
  - Minimum FU-to-CDB latency is 1 cycle.
  - `cdb_out` is combinational from registered state and the squash filter only, with no path from `fu_*`.
- **Throughput:** each FU can sustain one result per cycle while it is granted every cycle (same-cycle refill when granted).
- **Boundaries:**
  - Empty: no live entries gives no valid slots and `ptr` holds.
  - More than N live: the extra entries wait. Rotation guarantees each live entry is granted within ceil(NUM_FU/N) cycles.
  - `ptr` wraps from NUM_FU-1 to 0.
  - SQUASH and a new result in the same cycle: the filter applies to both held and incoming results.
  - Reset mid-operation discards all held results with no broadcast.

## Test plan
All directed tests use N=2, NUM_FU=4.
- **Reset / idle:** assert reset for 2 cycles → `cdb_out[0..1].valid=0`, `fu_ready=4'b1111`. After release with no inputs, outputs stay idle.
- **Single result latency:** at cycle 0, `fu_valid[2]` with reg 7, value 0xDEAD → cycle 1: `cdb_out[0]={1,7,0xDEAD}`, `cdb_out[1].valid=0`, `ptr` becomes 3.
- **Contention / rotation:**
  - Stimulus: all 4 FUs present results at cycle 0 and never again.
  - Cycle 1 broadcasts FU0 and FU1, `ptr`=2, and `fu_ready=4'b0011`.
  - Cycle 2 broadcasts FU2 and FU3.
  - Cycle 3 is idle.
- **Back-to-back refill:**
  - Stimulus: FU1 presents a new result every cycle for 5 cycles.
  - Five consecutive broadcasts in order, with `fu_ready[1]` high every cycle.
- **Squash:**
  - Setup: FU0 holds mask 4'b0010, FU1 holds mask 4'b0001, and `ptr`=0 (both held results are present at the start of the cycle).
  - Apply `br_task=SQUASH` with `br_id=4'b0010` for that cycle.
  - Response: only FU1 is broadcast that cycle, and FU0 is never broadcast.
  - Same cycle: an incoming FU3 result with mask 4'b0010 is dropped, and `fu_ready[3]=1`.
- **Clear:**
  - Setup: FU2 holds mask 4'b0110.
  - Apply `br_task=CLEAR` with `br_id=4'b0100`, then `SQUASH` with `br_id=4'b0100` on the next cycle.
  - Response: the FU2 result survives and is broadcast.

Source files
------------

// File: rtl/cdb_broadcast.sv
// Completion-stage CDB arbiter: one holding register per functional unit, up to N
// broadcasts per cycle by rotating priority, with branch squash / mask-clear.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 6
`endif
`ifndef BR_MASK_SZ
`define BR_MASK_SZ 4
`endif
`ifndef N
`define N 2
`endif
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 1
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 1
`endif
`ifndef NUM_FU_LD
`define NUM_FU_LD 1
`endif
`ifndef NUM_FU_STORE
`define NUM_FU_STORE 0
`endif
`ifndef NUM_FU_BR
`define NUM_FU_BR 1
`endif

package cdb_pkg;
  typedef logic [`BR_MASK_SZ-1:0] BR_MASK;

  typedef enum logic [1:0] {
    NOTHING = 2'd0,
    SQUASH  = 2'd1,
    CLEAR   = 2'd2
  } BR_TASK;

  typedef struct packed {
    logic                        valid;
    logic [`PHYS_REG_IDX_SZ-1:0] reg_idx;
    logic [`XLEN-1:0]            value;
  } CDB_PACKET;
endpackage

// Handshake: a result moves from FU i into its holding register on a clock edge
// where fu_valid[i] & fu_ready[i]; fu_ready is combinational and FUs must not
// make fu_valid depend on it. cdb_out slots carry no backpressure.
module cdb_broadcast
  import cdb_pkg::*;
#(
  parameter int N      = `N,
  parameter int NUM_FU = `NUM_FU_ALU + `NUM_FU_MULT + `NUM_FU_LD + `NUM_FU_STORE + `NUM_FU_BR
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUM_FU-1:0]                       fu_valid,
  input  logic [NUM_FU-1:0][`PHYS_REG_IDX_SZ-1:0] fu_reg_idx,
  input  logic [NUM_FU-1:0][`XLEN-1:0]            fu_value,
  input  BR_MASK [NUM_FU-1:0]                     fu_b_mask,
  input  BR_MASK                                  br_id,
  input  BR_TASK                                  br_task,
  output logic [NUM_FU-1:0]                       fu_ready,
  output CDB_PACKET [N-1:0]                       cdb_out
);

  localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int SLOT_W = (N > 1) ? $clog2(N) : 1;

  logic [NUM_FU-1:0]                       hold_valid;
  logic [NUM_FU-1:0][`PHYS_REG_IDX_SZ-1:0] hold_reg_idx;
  logic [NUM_FU-1:0][`XLEN-1:0]            hold_value;
  BR_MASK [NUM_FU-1:0]                     hold_b_mask;
  logic [PTR_W-1:0]                        ptr;
  logic [PTR_W-1:0]                        ptr_next;

  logic [NUM_FU-1:0] live;
  logic [NUM_FU-1:0] squashed;
  logic [NUM_FU-1:0] granted;
  logic [NUM_FU-1:0] in_drop;

  // Squash filter applies both to held entries and to results arriving this cycle.
  always_comb begin
    squashed = '0;
    in_drop  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      squashed[i] = hold_valid[i] && (br_task == SQUASH) && (|(hold_b_mask[i] & br_id));
      in_drop[i]  = (br_task == SQUASH) && (|(fu_b_mask[i] & br_id));
    end
    live = hold_valid & ~squashed;
  end

  always_comb begin
    int idx;
    int cnt;
    granted  = '0;
    cdb_out  = '0;
    ptr_next = ptr;
    cnt      = 0;
    idx      = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (live[PTR_W'(idx)] && (cnt < N)) begin
        granted[PTR_W'(idx)]               = 1'b1;
        cdb_out[SLOT_W'(cnt)].valid   = 1'b1;
        cdb_out[SLOT_W'(cnt)].reg_idx = hold_reg_idx[PTR_W'(idx)];
        cdb_out[SLOT_W'(cnt)].value   = hold_value[PTR_W'(idx)];
        cnt = cnt + 1;
        ptr_next = (idx == NUM_FU - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  // A slot freed this cycle (granted or squashed) can be refilled at the same edge.
  assign fu_ready = ~hold_valid | granted | squashed;

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid   <= '0;
      hold_reg_idx <= '0;
      hold_value   <= '0;
      hold_b_mask  <= '0;
      ptr          <= '0;
    end else begin
      ptr <= ptr_next;
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          hold_valid[i]   <= ~in_drop[i];
          hold_reg_idx[i] <= fu_reg_idx[i];
          hold_value[i]   <= fu_value[i];
          hold_b_mask[i]  <= (br_task == CLEAR) ? (fu_b_mask[i] & ~br_id) : fu_b_mask[i];
        end else if (granted[i] || squashed[i]) begin
          hold_valid[i] <= 1'b0;
        end else if (br_task == CLEAR) begin
          hold_b_mask[i] <= hold_b_mask[i] & ~br_id;
        end
      end
    end
  end

endmodule
